ps2_command_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It shares the PS2_CLK/PS2_DAT open-drain lines with the existing PS/2 receive path and runs the full protocol: clock inhibit, request-to-send, 11-clock frame and device ACK. It reports success or timeout with single-cycle pulses. While busy is high, the receive path ignores line activity.

---
 rtl/ps2_command_tx_pkg.sv | 32 +++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_command_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_command_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_command_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device command transmitter.
package ps2_command_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INHIBIT   = 4'd1,
    ST_RTS       = 4'd2,
    ST_WAIT_CLK  = 4'd3,
    ST_DATA      = 4'd4,
    ST_PARITY    = 4'd5,
    ST_STOP      = 4'd6,
    ST_WAIT_IDLE = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERROR     = 4'd9
  } state_t;

  localparam int TIMER_W = 20;

  localparam int unsigned DEF_INHIBIT_CYCLES        = 32'd6000;
  localparam int unsigned DEF_START_TIMEOUT_CYCLES  = 32'd750000;
  localparam int unsigned DEF_PACKET_TIMEOUT_CYCLES = 32'd100000;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one PS/2 line.
// Resets to the idle-high level so no spurious edge appears after reset.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic line_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame,
// device ACK check and idle wait, reporting success or failure as pulses.
module ps2_command_tx
  import ps2_command_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES        = DEF_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT_CYCLES  = DEF_START_TIMEOUT_CYCLES,
  parameter int unsigned PACKET_TIMEOUT_CYCLES = DEF_PACKET_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] command_data,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 32'd1);
  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT_CYCLES - 32'd1);
  localparam logic [TIMER_W-1:0] PACKET_LAST  = TIMER_W'(PACKET_TIMEOUT_CYCLES - 32'd1);

  state_t             state_q;
  logic [7:0]         shift_q;
  logic               parity_q;
  logic [3:0]         bit_idx_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic               clk_low_q;
  logic               dat_low_q;
  logic               busy_q;
  logic               sent_q;
  logic               err_q;

  logic clk_s;
  logic clk_fall_s;
  logic dat_s;
  logic dat_fall_unused_s;

  ps2_line_sync u_clk_sync (
    .clk_i  (CLOCK_50),
    .rst_ni (reset),
    .line_i (PS2_CLK),
    .line_o (clk_s),
    .fall_o (clk_fall_s)
  );

  ps2_line_sync u_dat_sync (
    .clk_i  (CLOCK_50),
    .rst_ni (reset),
    .line_i (PS2_DAT),
    .line_o (dat_s),
    .fall_o (dat_fall_unused_s)
  );

  // Open-drain: only ever pull low or release.
  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

  assign timer_d = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + 20'd1;

  // Protocol sequencer; the packet timer runs unbroken from the first device
  // clock fall through to the idle check, so it bounds the whole frame.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      bit_idx_q <= 4'd0;
      timer_q   <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      timer_q <= timer_d;
      sent_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (send_command) begin
            shift_q   <= command_data;
            parity_q  <= odd_parity(command_data);
            busy_q    <= 1'b1;
            clk_low_q <= 1'b1;
            state_q   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (timer_q >= INHIBIT_LAST) begin
            dat_low_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= ST_RTS;
          end
        end
        ST_RTS: begin
          clk_low_q <= 1'b0;
          timer_q   <= '0;
          state_q   <= ST_WAIT_CLK;
        end
        ST_WAIT_CLK: begin
          if (clk_fall_s) begin
            dat_low_q <= ~shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= 4'd0;
            timer_q   <= '0;
            state_q   <= ST_DATA;
          end else if (timer_q >= START_LAST) begin
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_ERROR;
          end
        end
        ST_DATA: begin
          if (timer_q >= PACKET_LAST) begin
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_ERROR;
          end else if (clk_fall_s) begin
            if (bit_idx_q == 4'd7) begin
              dat_low_q <= ~parity_q;
              state_q   <= ST_PARITY;
            end else begin
              dat_low_q <= ~shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (timer_q >= PACKET_LAST) begin
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_ERROR;
          end else if (clk_fall_s) begin
            dat_low_q <= 1'b0;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (timer_q >= PACKET_LAST) begin
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_ERROR;
          end else if (clk_fall_s) begin
            // Eleventh fall: the device must be holding data low as its ACK.
            if (!dat_s) begin
              state_q <= ST_WAIT_IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_ERROR;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (timer_q >= PACKET_LAST) begin
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_ERROR;
          end else if (clk_s && dat_s) begin
            sent_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_ERROR: begin
          clk_low_q <= 1'b0;
          dat_low_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          clk_low_q <= 1'b0;
          dat_low_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy                          = busy_q;
  assign command_was_sent              = sent_q;
  assign error_communication_timed_out = err_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx: a PS/2 device model clocks frames in,
// and a scoreboard queue holds the byte/parity each frame must carry.
module tb_ps2_command_tx;
  import ps2_command_tx_pkg::*;

  localparam int INH = 40;
  localparam int STO = 500;
  localparam int PTO = 3000;
  localparam int H   = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] command_data = 8'h00;
  logic       send_command = 1'b0;
  logic       bfm_clk_low = 1'b0;
  logic       bfm_dat_low = 1'b0;
  wire        ps2_clk;
  wire        ps2_dat;
  logic       busy;
  logic       sent;
  logic       err;

  always #5 clk = ~clk;

  assign ps2_clk = bfm_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = bfm_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_command_tx #(
    .INHIBIT_CYCLES        (INH),
    .START_TIMEOUT_CYCLES  (STO),
    .PACKET_TIMEOUT_CYCLES (PTO)
  ) dut (
    .CLOCK_50                      (clk),
    .reset                         (reset),
    .command_data                  (command_data),
    .send_command                  (send_command),
    .PS2_CLK                       (ps2_clk),
    .PS2_DAT                       (ps2_dat),
    .busy                          (busy),
    .command_was_sent              (sent),
    .error_communication_timed_out (err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       parity;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int   cyc = 0;
  int   sent_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   last_pulse_cyc = 0, last_err_cyc = 0, busy_fall_cyc = 0;
  int   low_run = 0, last_low_run = 0, rel_cyc = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sent === 1'b1) begin sent_cnt++; last_pulse_cyc = cyc; end
    if (err === 1'b1) begin err_cnt++; last_pulse_cyc = cyc; last_err_cyc = cyc; end
    if (sent === 1'b1 && err === 1'b1) both_cnt++;
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    busy_prev = busy;
    if (ps2_clk === 1'b0 && !bfm_clk_low) begin
      low_run++;
    end else if (low_run > 0) begin
      last_low_run = low_run;
      rel_cyc = cyc;
      low_run = 0;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycles=%0d expected finish before 60000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] b);
    command_data = b;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
  endtask

  task automatic bfm_frame(input bit ack, input int nfalls, output logic [9:0] bits);
    int n = 0;
    bits = '0;
    while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", (n < 3000), 1'b1);
    if (n >= 3000) return;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && ack) begin
        bfm_dat_low = 1'b1;
        repeat (H / 2) @(negedge clk);
      end
      bfm_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      bfm_clk_low = 1'b0;
      if (i <= 10) bits[i-1] = ps2_dat;
      repeat (H) @(negedge clk);
    end
    bfm_dat_low = 1'b0;
  endtask

  task automatic check_frame(input logic [9:0] bits);
    exp_t e;
    check("sb_nonempty", (sb_q.size() != 0), 1'b1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("frame_data", bits[7:0], e.data);
    check("frame_parity", bits[8], e.parity);
    check("frame_stop", bits[9], 1'b1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < limit);
    check("busy_drop", busy, 1'b0);
    #1;
  endtask

  task automatic run_ok(input logic [7:0] b, input logic p);
    logic [9:0] bits;
    int s0, e0;
    s0 = sent_cnt;
    e0 = err_cnt;
    sb_q.push_back('{data: b, parity: p});
    issue(b);
    bfm_frame(1'b1, 11, bits);
    check_frame(bits);
    wait_done(2000);
    check("sent_pulses", sent_cnt - s0, 1);
    check("err_pulses", err_cnt - e0, 0);
    check("busy_after_pulse", busy_fall_cyc - last_pulse_cyc, 1);
    check("inhibit_long", (last_low_run >= INH), 1'b1);
  endtask

  initial begin
    logic [9:0] bits;
    int s0, e0;

    repeat (5) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_sent", sent, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_clk_rel", ps2_clk, 1'b1);
    check("rst_dat_rel", ps2_dat, 1'b1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    run_ok(PS2_CMD_SET_LEDS, 1'b1);
    run_ok(PS2_CMD_ENABLE, 1'b0);
    run_ok(8'h00, 1'b1);
    run_ok(PS2_CMD_RESET, 1'b1);

    // No device: the line is never clocked after release.
    s0 = sent_cnt;
    e0 = err_cnt;
    issue(PS2_CMD_RESET);
    wait_done(INH + STO + 200);
    check("nodev_err", err_cnt - e0, 1);
    check("nodev_sent", sent_cnt - s0, 0);
    check("nodev_timeout", last_err_cyc - rel_cyc, STO);
    check("nodev_busy_after", busy_fall_cyc - last_pulse_cyc, 1);
    check("nodev_clk_rel", ps2_clk, 1'b1);
    check("nodev_dat_rel", ps2_dat, 1'b1);

    // Device never acknowledges.
    s0 = sent_cnt;
    e0 = err_cnt;
    sb_q.push_back('{data: PS2_CMD_ENABLE, parity: 1'b0});
    issue(PS2_CMD_ENABLE);
    bfm_frame(1'b0, 11, bits);
    check_frame(bits);
    wait_done(2000);
    check("nack_err", err_cnt - e0, 1);
    check("nack_sent", sent_cnt - s0, 0);

    // Reset in the middle of the frame after the fourth fall.
    issue(8'h00);
    bfm_frame(1'b1, 4, bits);
    check("mid_dat_driven", ps2_dat, 1'b0);
    check("mid_busy", busy, 1'b1);
    s0 = sent_cnt;
    e0 = err_cnt;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_clk", ps2_clk, 1'b1);
    check("mid_rst_dat", ps2_dat, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_rst_nopulse", (sent_cnt - s0) + (err_cnt - e0), 0);
    check("mid_rst_idle", busy, 1'b0);
    run_ok(PS2_CMD_ENABLE, 1'b0);

    // send_command held high; data changed after acceptance.
    s0 = sent_cnt;
    sb_q.push_back('{data: PS2_CMD_SET_LEDS, parity: 1'b1});
    command_data = PS2_CMD_SET_LEDS;
    send_command = 1'b1;
    repeat (3) @(negedge clk);
    command_data = 8'h00;
    bfm_frame(1'b1, 11, bits);
    check_frame(bits);
    wait_done(2000);
    check("hold_sent1", sent_cnt - s0, 1);
    @(negedge clk);
    check("hold_restart", busy, 1'b1);
    send_command = 1'b0;
    sb_q.push_back('{data: 8'h00, parity: 1'b1});
    bfm_frame(1'b1, 11, bits);
    check_frame(bits);
    wait_done(2000);
    check("hold_sent2", sent_cnt - s0, 2);
    repeat (20) @(negedge clk);
    check("hold_no_third", busy, 1'b0);

    check("pulse_overlap", both_cnt, 0);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
